// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler and scoreboard for the CPU register file.
// Round-robin arbitration between the ALU (port A) and the load unit (port B)
// for the single register file write port. A busy bit per register tracks
// writes in flight so that decode can see read-after-write hazards and
// refuse write-after-write issues.
//
// prio     | meaning
// ---------+------------------------------------------------
// PRIO_A   | port A wins the next cycle where both ports request
// PRIO_B   | port B wins the next cycle where both ports request
module regfile_write_scheduler #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [RF_ADDR_LEN-1:0] issue_rd,
  output logic                   issue_ready,
  input  logic [RF_ADDR_LEN-1:0] chk_rs1_addr,
  input  logic [RF_ADDR_LEN-1:0] chk_rs2_addr,
  output logic                   hazard,
  input  logic                   a_valid,
  input  logic [RF_ADDR_LEN-1:0] a_rd,
  input  logic [RF_DATA_LEN-1:0] a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [RF_ADDR_LEN-1:0] b_rd,
  input  logic [RF_DATA_LEN-1:0] b_data,
  output logic                   b_ready,
  output logic                   rf_w_en,
  output logic [RF_ADDR_LEN-1:0] rf_rd_addr,
  output logic [RF_DATA_LEN-1:0] rf_rd_write_data,
  output logic [RF_ADDR_LEN:0]   busy_count
);

  localparam int NUM_REGS = 1 << RF_ADDR_LEN;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t                 prio;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [RF_ADDR_LEN:0]  busy_count_nxt;
  logic                  grant_a;
  logic                  grant_b;
  logic                  set_eff;
  logic                  clr_eff;

  // Decode-facing scoreboard lookups and the round-robin grant.
  always_comb begin
    issue_ready = (issue_rd == '0) || !busy[issue_rd];
    hazard      = busy[chk_rs1_addr] | busy[chk_rs2_addr];
    grant_a     = a_valid && (!b_valid || (prio == PRIO_A));
    grant_b     = b_valid && (!a_valid || (prio == PRIO_B));
    a_ready     = grant_a;
    b_ready     = grant_b;
  end

  // Next scoreboard: the in-flight write clears first, then a new issue sets,
  // so an issue that coincides with a write to the same (non-busy) register
  // still leaves the register marked busy for the younger instruction.
  always_comb begin
    set_eff  = issue_valid && issue_ready && (issue_rd != '0);
    clr_eff  = rf_w_en && busy[rf_rd_addr];
    busy_nxt = busy;
    if (clr_eff) busy_nxt[rf_rd_addr] = 1'b0;
    if (set_eff) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    busy_count_nxt = busy_count;
    unique case ({set_eff, clr_eff})
      2'b10:   busy_count_nxt = busy_count + {{RF_ADDR_LEN{1'b0}}, 1'b1};
      2'b01:   busy_count_nxt = busy_count - {{RF_ADDR_LEN{1'b0}}, 1'b1};
      default: busy_count_nxt = busy_count;
    endcase
  end

  // Scoreboard state, priority pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= '0;
      busy_count       <= '0;
      prio             <= PRIO_A;
      rf_w_en          <= 1'b0;
      rf_rd_addr       <= '0;
      rf_rd_write_data <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= busy_count_nxt;
      if (grant_a) begin
        prio             <= PRIO_B;
        rf_w_en          <= (a_rd != '0);
        rf_rd_addr       <= a_rd;
        rf_rd_write_data <= a_data;
      end else if (grant_b) begin
        prio             <= PRIO_A;
        rf_w_en          <= (b_rd != '0);
        rf_rd_addr       <= b_rd;
        rf_rd_write_data <= b_data;
      end else begin
        rf_w_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with hand-computed expectations.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  chk_rs1_addr;
  logic [4:0]  chk_rs2_addr;
  logic        hazard;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_w_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_write_data;
  logic [5:0]  busy_count;

  int vectors = 0;
  int miscompares = 0;

  regfile_write_scheduler #(.RF_ADDR_LEN(5), .RF_DATA_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1_addr(chk_rs1_addr), .chk_rs2_addr(chk_rs2_addr), .hazard(hazard),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_w_en(rf_w_en), .rf_rd_addr(rf_rd_addr),
    .rf_rd_write_data(rf_rd_write_data), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = '0;
    chk_rs1_addr = '0; chk_rs2_addr = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    tick();
    tick();
    chk("rst_w_en", rf_w_en, 0);
    chk("rst_addr", rf_rd_addr, 0);
    chk("rst_data", rf_rd_write_data, 0);
    chk("rst_count", busy_count, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_issue_ready", issue_ready, 1);
    rst = 1'b0;

    // Reset mid-activity
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0; issue_rd = '0;
    chk_rs1_addr = 5'd3; chk_rs2_addr = 5'd5;
    settle();
    chk("mid_hazard_pre", hazard, 1);
    chk("mid_count_pre", busy_count, 2);
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'd5; rst = 1'b1;
    settle();
    chk("mid_a_ready", a_ready, 1);
    tick();
    rst = 1'b0; a_valid = 1'b0;
    settle();
    chk("mid_w_en", rf_w_en, 0);
    chk("mid_count", busy_count, 0);
    chk("mid_hazard", hazard, 0);

    // Issue then clear of register 8
    chk_rs1_addr = 5'd8; chk_rs2_addr = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd8;
    settle();
    chk("ic_issue_ready", issue_ready, 1);
    chk("ic_hazard0", hazard, 0);
    tick();
    issue_valid = 1'b0; issue_rd = '0;
    a_valid = 1'b1; a_rd = 5'd8; a_data = 32'd24;
    settle();
    chk("ic_hazard1", hazard, 1);
    chk("ic_count1", busy_count, 1);
    chk("ic_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    settle();
    chk("ic_w_en", rf_w_en, 1);
    chk("ic_addr", rf_rd_addr, 8);
    chk("ic_data", rf_rd_write_data, 24);
    chk("ic_hazard2", hazard, 1);
    chk("ic_count2", busy_count, 1);
    tick();
    chk("ic_hazard3", hazard, 0);
    chk("ic_count3", busy_count, 0);
    chk("ic_w_en_off", rf_w_en, 0);

    // Return priority to A before contention
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Contention: grants alternate A, B, A, B
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'd3;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'd27;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ct_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      chk("ct_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        chk("ct_w_en", rf_w_en, 1);
        chk("ct_addr", rf_rd_addr, (i % 2 == 1) ? 1 : 9);
        chk("ct_data", rf_rd_write_data, (i % 2 == 1) ? 3 : 27);
      end
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    settle();
    chk("ct_w_en_last", rf_w_en, 1);
    chk("ct_addr_last", rf_rd_addr, 9);
    chk("ct_data_last", rf_rd_write_data, 27);
    chk("ct_count", busy_count, 0);
    tick();
    chk("ct_w_en_off", rf_w_en, 0);

    // x0 handling (priority now A after the final B grant)
    issue_valid = 1'b1; issue_rd = 5'd0;
    settle();
    chk("x0_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("x0_count0", busy_count, 0);
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'd3;
    settle();
    chk("x0_b_ready", b_ready, 1);
    chk("x0_a_ready", a_ready, 0);
    tick();
    b_valid = 1'b0;
    settle();
    chk("x0_w_en", rf_w_en, 0);
    chk("x0_addr", rf_rd_addr, 0);
    chk("x0_data", rf_rd_write_data, 3);
    chk("x0_count1", busy_count, 0);
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'd30;
    settle();
    chk("x0_a10_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    settle();
    chk("x0_w10_en", rf_w_en, 1);
    chk("x0_w10_addr", rf_rd_addr, 10);
    chk("x0_w10_data", rf_rd_write_data, 30);
    tick();

    // WAW refusal on register 6, then simultaneous issue 7 / clear 6
    issue_valid = 1'b1; issue_rd = 5'd6;
    settle();
    chk("waw_first_ready", issue_ready, 1);
    tick();
    settle();
    chk("waw_refused0", issue_ready, 0);
    chk("waw_count", busy_count, 1);
    tick();
    a_valid = 1'b1; a_rd = 5'd6; a_data = 32'd66;
    settle();
    chk("waw_refused1", issue_ready, 0);
    chk("waw_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    settle();
    chk("waw_refused2", issue_ready, 0);
    chk("sim_w_en", rf_w_en, 1);
    chk("sim_addr", rf_rd_addr, 6);
    issue_rd = 5'd7;
    settle();
    chk("sim_issue7_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0; issue_rd = 5'd6;
    settle();
    chk("waw_ready_again", issue_ready, 1);
    chk("sim_count", busy_count, 1);
    chk_rs1_addr = 5'd7; chk_rs2_addr = 5'd0;
    settle();
    chk("sim_busy7", hazard, 1);
    chk_rs1_addr = 5'd6;
    settle();
    chk("sim_busy6", hazard, 0);
    chk("sim_w_en_off", rf_w_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Write-port scheduler and scoreboard for the CPU register file. Shares the register file's single write port between two writeback requesters, the ALU (port A) and the load unit (port B), using round-robin arbitration with valid/ready handshakes. Tracks which destination registers have writes outstanding and flags read-after-write hazards to decode. Sits between issue/writeback logic and `register_file`, driving its `w_en`, `rd_addr` and `rd_write_data` inputs.

## Interface
- RF_ADDR_LEN, 5, register address width; the block handles 2^RF_ADDR_LEN registers.
- RF_DATA_LEN, 32, register data width.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode announces an instruction that will write `issue_rd`.
- issue_rd  in  RF_ADDR_LEN  destination register of the issuing instruction.
- issue_ready  out  1  combinational: high when `issue_rd == 0` or `busy[issue_rd] == 0`.
- chk_rs1_addr, chk_rs2_addr  in  RF_ADDR_LEN  each  source registers of the instruction in decode.
- hazard  out  1  combinational: high when `busy[chk_rs1_addr]` or `busy[chk_rs2_addr]` is set.
- a_valid, b_valid  in  1  each  writeback request from ALU / load unit.
- a_rd, b_rd  in  RF_ADDR_LEN  each  requested destination register.
- a_data, b_data  in  RF_DATA_LEN  each  requested write data.
- a_ready, b_ready  out  1  each  combinational grant; the request is consumed on a cycle where valid and ready are both high.
- rf_w_en  out  1  registered; drives `register_file.w_en`.
- rf_rd_addr  out  RF_ADDR_LEN  registered; drives `register_file.rd_addr`.
- rf_rd_write_data  out  RF_DATA_LEN  registered; drives `register_file.rd_write_data`.
- busy_count  out  RF_ADDR_LEN+1  registered; number of set busy bits.

## Operation
- Scoreboard: `busy` vector, one bit per register. `busy[0]` is hardwired to 0.
- Issue: when `issue_valid && issue_ready` and `issue_rd != 0`, set `busy[issue_rd]`. A write-after-write issue to a busy register is refused (`issue_ready` is low). An issue with `issue_rd == 0` is always accepted and sets nothing.
- Arbitration: `prio` flag, reset value A.
  - Only one requester valid: it is granted.
  - Both requesters valid: the one named by `prio` is granted.
  - After any grant, `prio` points to the requester that was not granted.
  - Neither valid: no grant, and `prio` holds.
  - At most one of `a_ready`/`b_ready` is high in any cycle. Each ready is low whenever its own valid is low.
- On a grant, register the winner's fields into `rf_rd_addr`/`rf_rd_write_data`. Set `rf_w_en = (winner_rd != 0)`.
  - Writes to x0 are consumed but never reach the register file.
  - With no grant, `rf_w_en = 0`, and addr/data hold their previous values.
- Busy clear: on the edge where `rf_w_en` is high, clear `busy[rf_rd_addr]`. This is the same edge at which `register_file` captures the data.
- A write to a register that is not busy is performed normally and leaves the scoreboard unchanged.
- Simultaneous events in one cycle:
  - An issue to reg r and a clear of reg r cannot coincide, because issue is refused while r is busy.
  - An issue to r and a clear of a different register s both take effect.
- `busy_count` tracks set bits: +1 on an effective set, −1 on a clear, net 0 when both occur.

## Timing
- Reset (synchronous, checked at the edge): busy = 0, prio = A, rf_w_en = 0, rf_rd_addr = 0, rf_rd_write_data = 0, busy_count = 0. Reset overrides any same-cycle issue or grant. In-flight registered writes are dropped.
- Issue in cycle N: busy is set at the end of N, so `hazard` and `issue_ready` reflect it from cycle N+1.
- Grant in cycle N:
  - `rf_w_en` is high during N+1.
  - The register file writes and busy clears at the end of N+1.
  - `hazard` for that register falls in N+2, and the register file read returns the new data from N+2.
- No bypassing: hazard latency from grant to clear is 2 cycles.
- Throughput is one write per cycle; back-to-back grants produce back-to-back `rf_w_en` pulses.

## Test plan
- Reset mid-activity: busy regs 3 and 5 set and an A grant pending, then `rst` asserted for 1 cycle. Required: next cycle rf_w_en = 0, busy_count = 0, hazard = 0 for rs1 = 3 / rs2 = 5.
- Issue/clear: issue rd = 8, then in the next cycle A writes rd = 8, data = 24.
  - hazard is high for chk_rs1 = 8 from the cycle after issue.
  - rf_w_en is high with addr 8 / data 24 one cycle after the grant.
  - hazard falls the cycle after that; busy_count goes 0→1→0.
- Contention: a_valid and b_valid both held high for 4 cycles (A rd = 1/data 3, B rd = 9/data 27). Required: grants A, B, A, B, and rf_w_en high for 4 consecutive cycles.
- x0 handling: issue rd = 0, then B writes rd = 0, data = 3. Required: issue accepted, busy_count stays 0, b_ready high, rf_w_en stays 0. A following write rd = 10, data = 30 appears normally.
- WAW refusal: issue rd = 6, then issue rd = 6 again. Required: issue_ready is low for the second issue until one cycle after the write to 6 is performed, then high again.
- Simultaneous issue and clear: in one cycle, issue rd = 7 while rf_w_en clears reg 6. Required: busy[7] = 1, busy[6] = 0, busy_count unchanged.
